// File: rtl/spi_slave.sv
// SPI slave peripheral: synchronizes an external SPI master's SCLK/MOSI/SS_n into i_clk
// and exchanges full-duplex bytes with a CPU through a 4-register bus.
module spi_slave #(
    parameter int unsigned CLK_FREQ    = 48_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_SCLK,
    input  logic       i_MOSI,
    input  logic       i_SS_n,
    output logic       o_MISO,
    output logic       o_MISO_oe,
    input  logic       i_en,
    input  logic       i_wr,
    input  logic [3:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    if (SYNC_STAGES < 2 || CLK_FREQ < 8) begin : g_param_chk
        $error("spi_slave: SYNC_STAGES must be >= 2 and CLK_FREQ >= 8");
    end

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

    state_e                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]   mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0]   ss_sync_q, ss_sync_d;
    logic                     sclk_prev_q, sclk_prev_d;
    logic                     ss_prev_q, ss_prev_d;
    logic [BYTE_W-1:0]        shifter_q, shifter_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic                     miso_q, miso_d;
    logic                     oe_q, oe_d;
    logic [2:0]               ctrl_q, ctrl_d;
    logic [BYTE_W-1:0]        rx_hold_q, rx_hold_d;
    logic [BYTE_W-1:0]        tx_hold_q, tx_hold_d;
    logic                     rx_full_q, rx_full_d;
    logic                     tx_empty_q, tx_empty_d;
    logic                     overrun_q, overrun_d;
    logic [BYTE_W-1:0]        data_q, data_d;

    logic sclk_s, mosi_s, ss_s;
    logic cpha, cpol, enable;
    logic lead_edge, trail_edge, sample_edge, shift_edge, ss_fall;
    logic wr_tx, wr_ctrl, wr_stat, rd_rx;
    logic load_avail;
    logic [BYTE_W-1:0] load_byte, rx_byte;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];

    assign cpha   = ctrl_q[0];
    assign cpol   = ctrl_q[1];
    assign enable = ctrl_q[2];

    // CPOL=1 inverts which SCLK transition counts as the leading edge.
    assign lead_edge   = cpol ? (sclk_prev_q & ~sclk_s) : (~sclk_prev_q & sclk_s);
    assign trail_edge  = cpol ? (~sclk_prev_q & sclk_s) : (sclk_prev_q & ~sclk_s);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;
    assign ss_fall     = ss_prev_q & ~ss_s;

    assign wr_tx   = i_en & i_wr & (i_addr == 4'h1);
    assign wr_ctrl = i_en & i_wr & (i_addr == 4'h3);
    assign wr_stat = i_en & i_wr & (i_addr == 4'h0);
    assign rd_rx   = i_en & ~i_wr & (i_addr == 4'h2);

    // A TX write coinciding with a reload goes straight into the shifter.
    assign load_avail = wr_tx | ~tx_empty_q;
    assign load_byte  = wr_tx ? i_data : (tx_empty_q ? 8'hFF : tx_hold_q);
    assign rx_byte    = {shifter_q[BYTE_W-2:0], mosi_s};

    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_SCLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_MOSI};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], i_SS_n};
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
        shifter_d   = shifter_q;
        bit_cnt_d   = bit_cnt_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        ctrl_d      = ctrl_q;
        rx_hold_d   = rx_hold_q;
        tx_hold_d   = tx_hold_q;
        rx_full_d   = rx_full_q;
        tx_empty_d  = tx_empty_q;
        overrun_d   = overrun_q;
        data_d      = data_q;

        if (i_en && !i_wr) begin
            case (i_addr)
                4'h0:    data_d = {3'b000, (bit_cnt_q != 3'd0), (~ss_s & enable),
                                   overrun_q, tx_empty_q, rx_full_q};
                4'h1:    data_d = tx_hold_q;
                4'h2:    data_d = rx_hold_q;
                4'h3:    data_d = {5'b00000, ctrl_q};
                default: data_d = 8'h00;
            endcase
        end
        if (wr_ctrl) ctrl_d = i_data[2:0];
        if (wr_stat && i_data[2]) overrun_d = 1'b0;
        if (wr_tx) begin
            tx_hold_d  = i_data;
            tx_empty_d = 1'b0;
        end
        if (rd_rx) rx_full_d = 1'b0;

        // SPI side is evaluated last so its flag updates win simultaneous events.
        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                oe_d   = 1'b0;
                if (enable && ss_fall) begin
                    state_d   = ST_ACTIVE;
                    oe_d      = 1'b1;
                    shifter_d = load_byte;
                    bit_cnt_d = 3'd0;
                    miso_d    = cpha ? 1'b0 : load_byte[BYTE_W-1];
                    if (load_avail) tx_empty_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_s || !enable) begin
                    state_d   = ST_IDLE;
                    oe_d      = 1'b0;
                    miso_d    = 1'b0;
                    bit_cnt_d = 3'd0;
                    shifter_d = 8'h00;
                end else begin
                    if (sample_edge) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_full_q && !rd_rx) begin
                                overrun_d = 1'b1;
                            end else begin
                                rx_hold_d = rx_byte;
                                rx_full_d = 1'b1;
                            end
                            shifter_d = load_byte;
                            if (load_avail) tx_empty_d = 1'b1;
                        end else begin
                            shifter_d = rx_byte;
                        end
                    end
                    if (shift_edge) miso_d = shifter_q[BYTE_W-1];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            shifter_q   <= 8'h00;
            bit_cnt_q   <= 3'd0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            ctrl_q      <= 3'd0;
            rx_hold_q   <= 8'h00;
            tx_hold_q   <= 8'h00;
            rx_full_q   <= 1'b0;
            tx_empty_q  <= 1'b1;
            overrun_q   <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
            shifter_q   <= shifter_d;
            bit_cnt_q   <= bit_cnt_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            ctrl_q      <= ctrl_d;
            rx_hold_q   <= rx_hold_d;
            tx_hold_q   <= tx_hold_d;
            rx_full_q   <= rx_full_d;
            tx_empty_q  <= tx_empty_d;
            overrun_q   <= overrun_d;
            data_q      <= data_d;
        end
    end

    assign o_MISO    = miso_q;
    assign o_MISO_oe = oe_q;
    assign o_data    = data_q;

endmodule
